alu_result_collector: RTL
=========================

Name: alu_result_collector

Overview:
- Downstream consumer of the 4-bit add/sub ALU.
- Registers each ALU result (sum, overflow flag, operator) into a small FIFO so a slower sink can drain it over a valid/ready handshake.
- Keeps a running signed sum of valid results with saturation, plus a sticky overflow flag, for the lab display/checker stage.

Parameters:
- DATA_W, 4, width of ALU result in_s.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- SUM_W, 8, width of signed running sum; must exceed DATA_W.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  ALU result present this cycle.
- in_ready  output  1  collector can accept.
- in_s  input  DATA_W  ALU result s, two's complement.
- in_ovf  input  1  ALU overflow flag.
- in_op  input  1  ALU operator: 0 add, 1 subtract.
- out_valid  output  1  head entry available.
- out_ready  input  1  sink pops head.
- out_data  output  DATA_W  head entry result.
- out_ovf  output  1  head entry overflow.
- out_op  output  1  head entry operator.
- count  output  $clog2(DEPTH)+1  FIFO occupancy.
- clear  input  1  synchronous clear of sum, sum_sat and sticky_ovf; FIFO untouched.
- sum  output  SUM_W  signed running sum.
- sum_sat  output  1  sum has saturated since last clear/reset.
- sticky_ovf  output  1  any accepted entry had in_ovf=1 since last clear/reset.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - count=0, out_valid=0, in_ready=1.
  - sum=0, sum_sat=0, sticky_ovf=0.
  - out_data/out_ovf/out_op=0; stored entries are don't-care.
  - Reset mid-traffic discards all entries.
- Handshakes:
  - Push when in_valid&in_ready.
  - Pop when out_valid&out_ready.
  - in_valid is independent of in_ready (no combinational loop).
- in_ready = (count<DEPTH), registered-state derived only. A full FIFO refuses a push even if a pop occurs the same cycle.
- out_valid = (count!=0). Output is first-word-fall-through: out_data/out_ovf/out_op show the head entry directly from storage; they are zero when empty.
- Latency: a pushed entry is visible at the output the cycle after the push.
- Simultaneous push and pop (0<count<DEPTH): count unchanged; pointers both advance.
- Pointers wrap modulo DEPTH. Order is strictly FIFO.
- Entry format: {op, ovf, data}.
- Sum update on push:
  - If in_ovf=0: sum <= sat(sum + sign_ext(in_s)).
  - If in_ovf=1: sum unchanged and sticky_ovf <= 1. Overflowed results are still queued.
- Saturation:
  - Clamp to [-(2^(SUM_W-1)), 2^(SUM_W-1)-1].
  - Set sum_sat when clamping occurs.
  - sum_sat stays set until clear or reset.
- clear with a push in the same cycle:
  - Base is zero: sum <= sign_ext(in_s) if in_ovf=0, else 0.
  - sticky_ovf <= in_ovf.
  - sum_sat <= 0.
- rst_n has priority over clear and all handshakes.

Optional Feature:
- Macro COLLECT_OPCOUNT_EN.
- When defined:
  - Adds outputs add_cnt[7:0] and sub_cnt[7:0].
  - On each push, the counter selected by in_op increments, saturating at 255.
  - Both counters are zeroed by reset and clear.
  - If clear coincides with a push, the selected counter becomes 1.
- When undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package alu_collect_pkg:
  - DATA_W/SUM_W defaults.
  - Packed entry typedef {op, ovf, data}.
  - SUM_MAX/SUM_MIN constants.
  - OP_ADD=0, OP_SUB=1.
- One sub-module, alu_sat_acc: saturating signed accumulator with clear, add-enable and sat flag.
- FIFO storage and pointers stay in the top module.

Test Plan:
- Reset state: rst_n low 2 cycles, then high, no traffic -> count=0, out_valid=0, in_ready=1, sum=0, sum_sat=0, sticky_ovf=0.
- Order, fill and full:
  - Push s=7,1,-3(1101),2 (ovf=0) with out_ready=0 -> count=4, in_ready=0, sum=7.
  - Fifth push is refused.
  - Then out_ready=1 -> outputs 0111,0001,1101,0010 in order, count back to 0.
- Overflow handling: push s=1000 with in_ovf=1, in_op=0 -> queued with out_ovf=1, sticky_ovf=1, sum unchanged.
- Saturation:
  - Push s=1000 (ovf=0) 17 times while popping -> sum=-128 (0x80), sum_sat=1.
  - Push s=0111 -> sum=-121, sum_sat still 1.
- Simultaneous events:
  - count=2; push and pop in the same cycle -> count stays 2, head advances.
  - Assert clear together with a push of s=3 -> sum=3, sum_sat=0, sticky_ovf=0.
- Reset mid-operation: count=3, sum=20, then rst_n=0 for one cycle -> all outputs at reset values. With COLLECT_OPCOUNT_EN, add_cnt=sub_cnt=0.

Source files
------------

// File: rtl/alu_collect_pkg.sv
// Shared definitions for the ALU result collector.
//   DATA_W_DEF / DEPTH_DEF / SUM_W_DEF : default widths and FIFO depth
//   entry_t                            : queued entry layout {op, ovf, data}
//   SUM_MAX / SUM_MIN                  : running-sum clamp limits at SUM_W_DEF
//   OP_ADD / OP_SUB                    : ALU operator encodings
package alu_collect_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int DEPTH_DEF  = 4;
  localparam int SUM_W_DEF  = 8;

  typedef struct packed {
    logic                  op;
    logic                  ovf;
    logic [DATA_W_DEF-1:0] data;
  } entry_t;

  localparam logic signed [SUM_W_DEF-1:0] SUM_MAX = {1'b0, {(SUM_W_DEF-1){1'b1}}};
  localparam logic signed [SUM_W_DEF-1:0] SUM_MIN = {1'b1, {(SUM_W_DEF-1){1'b0}}};

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/alu_sat_acc.sv
// Saturating signed accumulator.
//   clk, rst_n  : clock, synchronous active-low reset
//   clear_i     : restart from zero (an add in the same cycle lands on zero)
//   add_en_i    : add sign-extended addend_i this cycle
//   addend_i    : two's complement addend, DATA_W bits
//   sum_o       : signed running sum, SUM_W bits
//   sat_o       : a clamp has happened since the last clear/reset
module alu_sat_acc
  import alu_collect_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SUM_W  = SUM_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              add_en_i,
  input  logic [DATA_W-1:0] addend_i,
  output logic [SUM_W-1:0]  sum_o,
  output logic              sat_o
);

  // One guard bit is enough: |sum| + |addend| never exceeds 2^SUM_W.
  localparam logic signed [SUM_W:0] MAX_W = {2'b00, {(SUM_W-1){1'b1}}};
  localparam logic signed [SUM_W:0] MIN_W = {2'b11, {(SUM_W-1){1'b0}}};

  logic [SUM_W-1:0]        sum_q, sum_d;
  logic                    sat_q, sat_d;
  logic signed [SUM_W:0]   base_w;
  logic signed [SUM_W:0]   addend_w;
  logic signed [SUM_W:0]   total_w;

  assign base_w   = clear_i ? '0 : {sum_q[SUM_W-1], sum_q};
  assign addend_w = {{(SUM_W+1-DATA_W){addend_i[DATA_W-1]}}, addend_i};
  assign total_w  = base_w + addend_w;

  always_comb begin
    sum_d = base_w[SUM_W-1:0];
    sat_d = clear_i ? 1'b0 : sat_q;
    if (add_en_i) begin
      if (total_w > MAX_W) begin
        sum_d = MAX_W[SUM_W-1:0];
        sat_d = 1'b1;
      end else if (total_w < MIN_W) begin
        sum_d = MIN_W[SUM_W-1:0];
        sat_d = 1'b1;
      end else begin
        sum_d = total_w[SUM_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q <= '0;
      sat_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      sat_q <= sat_d;
    end
  end

  assign sum_o = sum_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/alu_result_collector.sv
// Collects 4-bit add/sub ALU results into a first-word-fall-through FIFO
// drained over valid/ready, and keeps a saturating running sum plus a
// sticky overflow flag.
//   clk, rst_n                     : clock, synchronous active-low reset
//   in_valid/in_ready, in_s/in_ovf/in_op : ALU result push side
//   out_valid/out_ready, out_data/out_ovf/out_op : head entry pop side
//   count                          : FIFO occupancy
//   clear                          : zero sum, sum_sat, sticky_ovf (FIFO kept)
//   sum, sum_sat, sticky_ovf       : running statistics
// Optional macro COLLECT_OPCOUNT_EN adds add_cnt/sub_cnt, saturating
// per-operator push counters.
module alu_result_collector
  import alu_collect_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int SUM_W  = SUM_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_s,
  input  logic                   in_ovf,
  input  logic                   in_op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_ovf,
  output logic                   out_op,
  output logic [$clog2(DEPTH):0] count,
  input  logic                   clear,
  output logic [SUM_W-1:0]       sum,
  output logic                   sum_sat,
`ifdef COLLECT_OPCOUNT_EN
  output logic [7:0]             add_cnt,
  output logic [7:0]             sub_cnt,
`endif
  output logic                   sticky_ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = DATA_W + 2;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sticky_q, sticky_d;
  logic             push, pop;
  logic [ENT_W-1:0] head;

  // Ready depends only on stored occupancy, so a full FIFO refuses a push
  // even when the sink pops in the same cycle.
  assign in_ready  = (count_q < FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign head = out_valid ? mem_q[rd_ptr_q] : '0;
  assign {out_op, out_ovf, out_data} = head;
  assign count = count_q;

  // Pointers are PTR_W wide, so DEPTH being a power of two makes wrap free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    sticky_d = clear ? 1'b0 : sticky_q;
    if (push && in_ovf) sticky_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_op, in_ovf, in_s};
  end

  assign sticky_ovf = sticky_q;

  // Overflowed results are queued but kept out of the sum.
  alu_sat_acc #(
    .DATA_W (DATA_W),
    .SUM_W  (SUM_W)
  ) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (clear),
    .add_en_i (push & ~in_ovf),
    .addend_i (in_s),
    .sum_o    (sum),
    .sat_o    (sum_sat)
  );

`ifdef COLLECT_OPCOUNT_EN
  logic [7:0] add_cnt_q, add_cnt_d;
  logic [7:0] sub_cnt_q, sub_cnt_d;

  always_comb begin
    add_cnt_d = clear ? 8'd0 : add_cnt_q;
    sub_cnt_d = clear ? 8'd0 : sub_cnt_q;
    if (push) begin
      if (in_op == OP_SUB) begin
        if (sub_cnt_d != 8'hFF) sub_cnt_d = sub_cnt_d + 8'd1;
      end else begin
        if (add_cnt_d != 8'hFF) add_cnt_d = add_cnt_d + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      add_cnt_q <= 8'd0;
      sub_cnt_q <= 8'd0;
    end else begin
      add_cnt_q <= add_cnt_d;
      sub_cnt_q <= sub_cnt_d;
    end
  end

  assign add_cnt = add_cnt_q;
  assign sub_cnt = sub_cnt_q;
`endif

endmodule
